// File: rtl/prbs5_checker.sv
// rtl/prbs5_checker.sv - self-synchronising x^5+x^2+1 PRBS bit-error checker
// Optional bit_cnt output when PRBS5_CHK_BITCNT_EN is defined.
module prbs5_checker #(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
`ifdef PRBS5_CHK_BITCNT_EN
    output logic [CNT_W-1:0] bit_cnt,
`endif
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [4:0] LOCK_C    = 5'(LOCK_CNT);
    localparam logic [4:0] LOSS_C    = 5'(LOSS_CNT);
    localparam logic [2:0] FILL_FULL = 3'd5;

    state_t     state;
    logic [4:0] ref_q;
    logic [2:0] fill;
    logic [4:0] match_cnt;
    logic [4:0] miss_cnt;

    logic       pred;
    logic       hit;
    logic       err_bit;
    logic [4:0] match_nxt;
    logic [4:0] miss_nxt;

    // ref_q[0] is the newest bit, so b[n] = b[n-2] ^ b[n-5].
    assign pred      = ref_q[1] ^ ref_q[4];
    assign hit       = (|ref_q) && (din == pred);
    assign match_nxt = match_cnt + 5'd1;
    assign miss_nxt  = miss_cnt + 5'd1;
    assign err_bit   = din_vld && (state == LOCKED) && (din != pred);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEARCH;
            ref_q     <= '0;
            fill      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (din_vld) begin
                case (state)
                    SEARCH: begin
                        ref_q <= {ref_q[3:0], din};
                        if (fill != FILL_FULL) begin
                            fill <= fill + 3'd1;
                        end else if (hit) begin
                            if (match_nxt == LOCK_C) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                miss_cnt  <= '0;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_nxt;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-run on the local prediction so a flipped bit costs one error only.
                        ref_q <= {ref_q[3:0], pred};
                        if (din != pred) begin
                            err_pulse <= 1'b1;
                            if (miss_nxt == LOSS_C) begin
                                state     <= SEARCH;
                                locked    <= 1'b0;
                                fill      <= '0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_nxt;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (err_bit && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

`ifdef PRBS5_CHK_BITCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
        end else if (clr_cnt) begin
            bit_cnt <= '0;
        end else if (din_vld && (state == LOCKED) && (bit_cnt != '1)) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_prbs5_checker.sv
// tb/tb_prbs5_checker.sv - randomized bench for prbs5_checker against a bit-history model
module tb_prbs5_checker;

    localparam int LOCK_N = 8;
    localparam int LOSS_N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic        din_vld;
    logic        clr_cnt;
    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic        locked_b, err_pulse_b;
    logic [1:0]  err_cnt_b;
`ifdef PRBS5_CHK_BITCNT_EN
    logic [15:0] bit_cnt;
    logic [1:0]  bit_cnt_b;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prbs5_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse),
`ifdef PRBS5_CHK_BITCNT_EN
        .bit_cnt(bit_cnt),
`endif
        .err_cnt(err_cnt)
    );

    prbs5_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
        .locked(locked_b), .err_pulse(err_pulse_b),
`ifdef PRBS5_CHK_BITCNT_EN
        .bit_cnt(bit_cnt_b),
`endif
        .err_cnt(err_cnt_b)
    );

    // Generator: history of emitted bits, oldest first, seeded 00001.
    bit g_hist[$] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reference: recent bits since (re)entering search; size 5 means the window is full.
    bit m_hist[$];
    bit m_locked, m_pulse;
    int m_match, m_miss, m_err, m_bits;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit gen_next();
        bit b;
        b = g_hist[3] ^ g_hist[0];
        g_hist.push_back(b);
        void'(g_hist.pop_front());
        return b;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_locked = 0; m_pulse = 0;
        m_match = 0; m_miss = 0; m_err = 0; m_bits = 0;
    endtask

    task automatic model(input bit d, input bit v, input bit c);
        bit p, nz;
        m_pulse = 0;
        if (v) begin
            if (m_locked) begin
                p = m_hist[3] ^ m_hist[0];
                m_bits++;
                m_hist.push_back(p);
                void'(m_hist.pop_front());
                if (d != p) begin
                    m_pulse = 1;
                    m_err++;
                    m_miss++;
                    if (m_miss == LOSS_N) begin
                        m_locked = 0; m_miss = 0; m_match = 0;
                        m_hist.delete();
                    end
                end else begin
                    m_miss = 0;
                end
            end else begin
                if (m_hist.size() == 5) begin
                    p = m_hist[3] ^ m_hist[0];
                    nz = 0;
                    foreach (m_hist[i]) nz |= m_hist[i];
                    if (nz && d == p) begin
                        m_match++;
                        if (m_match == LOCK_N) begin
                            m_locked = 1; m_miss = 0; m_match = 0;
                        end
                    end else begin
                        m_match = 0;
                    end
                end
                m_hist.push_back(d);
                if (m_hist.size() > 5) void'(m_hist.pop_front());
            end
        end
        if (c) begin
            m_err = 0;
            m_bits = 0;
        end
    endtask

    task automatic step(input bit d, input bit v, input bit c);
        din = d; din_vld = v; clr_cnt = c;
        model(d, v, c);
        @(posedge clk);
        #1;
        chk("locked", locked, m_locked);
        chk("err_pulse", err_pulse, m_pulse);
        chk("err_cnt", err_cnt, sat(m_err, 65535));
        chk("locked_w2", locked_b, m_locked);
        chk("err_cnt_w2", err_cnt_b, sat(m_err, 3));
`ifdef PRBS5_CHK_BITCNT_EN
        chk("bit_cnt", bit_cnt, sat(m_bits, 65535));
        chk("bit_cnt_w2", bit_cnt_b, sat(m_bits, 3));
`endif
    endtask

    task automatic send(input bit flip, input bit v, input bit c);
        bit d;
        if (v) d = gen_next() ^ flip;
        else   d = 1'($urandom);
        step(d, v, c);
    endtask

    task automatic do_reset();
        rst = 0; din = 0; din_vld = 0; clr_cnt = 0;
        model_reset();
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    // Returns the number of valid bits consumed until locked, or -1 within the budget.
    task automatic lock_up(input bit gaps, output int nvalid);
        int n;
        bit v;
        n = 0;
        nvalid = -1;
        for (int i = 0; i < 80 && nvalid < 0; i++) begin
            v = gaps ? (i % 2 == 0) : 1'b1;
            send(0, v, 0);
            if (v) n++;
            if (locked === 1'b1) nvalid = n;
        end
    endtask

    initial begin
        int n;
        int burst;
        bit ever;
        bit v, f;

        do_reset();

        // continuous stream: lock after 13 valid bits, clean for 200
        lock_up(0, n);
        chk("lock_at_13", n, 13);
        for (int i = n; i < 200; i++) send(0, 1, 0);
        chk("clean_err_cnt", err_cnt, 0);

        // alternating valid
        do_reset();
        lock_up(1, n);
        chk("gap_lock_at_13", n, 13);

        // single flipped bit
        send(1, 1, 0);
        chk("single_err", err_cnt, 1);
        chk("single_locked", locked, 1);
        for (int i = 0; i < 30; i++) send(0, 1, 0);
        chk("single_err_after", err_cnt, 1);

        // four consecutive errors lose lock, then re-lock
        do_reset();
        lock_up(0, n);
        for (int i = 0; i < 4; i++) send(1, 1, 0);
        chk("loss_locked", locked, 0);
        chk("loss_err_cnt", err_cnt, 4);
        lock_up(0, n);
        chk("relock_at_13", n, 13);
        chk("relock_err_cnt", err_cnt, 4);

        // stuck lines never lock
        do_reset();
        ever = 0;
        for (int i = 0; i < 200; i++) begin
            step(i >= 100, 1, 0);
            if (locked !== 1'b0) ever = 1;
        end
        chk("stuck_never_lock", ever, 0);

        // saturation in the 2-bit instance, then clear beating an error
        do_reset();
        lock_up(0, n);
        for (int i = 0; i < 5; i++) begin
            send(1, 1, 0);
            for (int j = 0; j < 3; j++) send(0, 1, 0);
        end
        chk("sat_w2", err_cnt_b, 3);
        chk("sat_w16", err_cnt, 5);
        send(1, 1, 1);
        chk("clr_wins", err_cnt, 0);
        chk("clr_wins_w2", err_cnt_b, 0);

        // async reset while locked with errors counted
        send(1, 1, 0);
        chk("pre_rst_locked", locked, 1);
        rst = 0;
        #1;
        chk("async_locked", locked, 0);
        chk("async_err_cnt", err_cnt, 0);
        chk("async_pulse", err_pulse, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;

        // randomized traffic
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom % 4) != 0;
            f = 0;
            if (v) begin
                if (burst > 0) begin
                    f = 1;
                    burst--;
                end else if ($urandom % 250 == 0) begin
                    burst = $urandom_range(1, 6);
                end else begin
                    f = ($urandom % 60) == 0;
                end
            end
            send(f, v, ($urandom % 150) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs5_checker.md
Name: prbs5_checker

Overview:
Serial checker for the 5-bit maximal-length PRBS stream (polynomial x^5+x^2+1, period 31) produced by the team's 5-bit sequence generator. It sits directly downstream of the generator or of the link it drives. It self-synchronises to the incoming bit stream, declares lock, then free-runs a local reference LFSR and counts bit errors against it. It drops lock on a burst of consecutive errors.

Parameters:
LOCK_CNT, 8, consecutive correct predictions needed to enter LOCKED (1..31)
LOSS_CNT, 4, consecutive mismatches in LOCKED that force return to SEARCH (1..31)
CNT_W, 16, width of saturating error counter (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low
din  input  1  received serial PRBS bit
din_vld  input  1  din qualifier; state advances only when high
clr_cnt  input  1  synchronous clear of err_cnt (and bit_cnt if enabled)
locked  output  1  high while in LOCKED state
err_pulse  output  1  one-cycle pulse per mismatched bit while LOCKED
err_cnt  output  CNT_W  saturating count of mismatched bits while LOCKED

Behaviour:
- Reset is asynchronous, active-low; clock is clk. On reset: state=SEARCH, ref=0, fill=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_cnt=0.
- Reference register ref[4:0], ref[0] newest bit. Prediction p = ref[1]^ref[4], equivalent to b[n]=b[n-2]^b[n-5].
- All updates occur only on cycles with din_vld=1. With din_vld=0, all state holds and err_pulse=0.
- SEARCH state:
  - ref <= {ref[3:0], din}.
  - fill counts 0..5 and saturates at 5. No comparison is made while fill<5.
  - With fill==5: if ref!=0 and din==p, match_cnt++. Otherwise match_cnt <= 0. An all-zero ref never counts as a match, so a stuck-at-0 line never locks.
  - When the increment makes match_cnt==LOCK_CNT: go to LOCKED, locked=1 on the next cycle, miss_cnt=0.
- LOCKED state:
  - ref <= {ref[3:0], p}. The local LFSR free-runs and ignores din, so one flipped bit gives exactly one error.
  - din!=p: err_pulse=1 next cycle, err_cnt++ (saturates at 2^CNT_W-1), miss_cnt++.
  - din==p: miss_cnt <= 0.
  - When miss_cnt reaches LOSS_CNT: go to SEARCH with locked=0 next cycle, fill=0, match_cnt=0. The LOSS_CNT-th error is still counted and pulsed.
- All outputs are registered. Latency from the sampled bit to locked/err_pulse/err_cnt update is 1 clk.
- clr_cnt=1 zeroes err_cnt on the next edge and wins over a simultaneous increment. clr_cnt does not affect state or locked.
- err_cnt is counted only in LOCKED. It holds its value through loss of lock and re-lock until clr_cnt or reset.
- Reset mid-operation returns immediately (asynchronously) to the reset values above.

Optional Feature:
Macro PRBS5_CHK_BITCNT_EN.
- Defined: adds output bit_cnt (CNT_W bits). It counts din_vld cycles while LOCKED, saturates at all-ones, is cleared by clr_cnt (clear wins) and by reset, and has 1-clk latency like err_cnt. A bit error rate is then err_cnt/bit_cnt.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Lock timing: generator seeded 5'b00001, din_vld=1 continuously. locked rises 1 clk after the 13th valid bit (5 fill + 8 matches). err_cnt=0 and err_pulse never fires over 200 bits.
- Valid gaps: same stream with din_vld toggling 1,0,1,0… locked rises after the 13th valid bit. State holds on idle cycles, err_pulse=0.
- Single error: once locked, invert one bit. Exactly one err_pulse, err_cnt=1, locked stays 1. Subsequent bits produce no further errors.
- Loss of lock: once locked, invert 4 consecutive bits. err_cnt=4 and locked=0 1 clk after the 4th. Re-lock 13 valid bits later, with err_cnt still 4.
- Degenerate input: din held at 0 for 100 valid bits, then din held at 1 for 100 valid bits. locked is never asserted.
- Counters: CNT_W=2 with 5 isolated errors gives err_cnt saturated at 3. clr_cnt asserted on the same cycle as an error gives err_cnt=0. Async reset asserted while locked clears locked and err_cnt within the same cycle.
